// File: rtl/alu_mul_seq_if.sv
// Request/result bundle between the processor and the MUL sequencer.
interface alu_mul_seq_if;
  logic       start_i;
  logic [7:0] a_i;
  logic [7:0] b_i;
  logic       busy_o;
  logic       done_o;
  logic [7:0] product_o;

  modport master (
    output start_i, a_i, b_i,
    input  busy_o, done_o, product_o
  );

  modport slave (
    input  start_i, a_i, b_i,
    output busy_o, done_o, product_o
  );
endinterface

// File: rtl/alu_mul_seq.sv
// Shift-add 8x8 multiplier (low byte) that borrows the shared ALU for all arithmetic.
module alu_mul_seq #(
  parameter int unsigned MAX_ITER = 8,
  parameter logic [2:0]  OP_AND   = 3'b000,
  parameter logic [2:0]  OP_ADD   = 3'b001,
  parameter logic [2:0]  OP_SLL   = 3'b010,
  parameter logic [2:0]  OP_SRL   = 3'b011,
  parameter logic [2:0]  OP_SEQ   = 3'b111
) (
  input  logic       clk_i,
  input  logic       reset_i,
  alu_mul_seq_if.slave bus,
  output logic [2:0] alu_opcode_o,
  output logic [7:0] alu_rs_o,
  output logic [7:0] alu_rt_o,
  input  logic [7:0] alu_result_i,
  input  logic       alu_zero_i
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHK,
    S_ADD,
    S_SHL,
    S_SHR,
    S_DONE
  } state_t;

  localparam logic [2:0] LAST_ITER = 3'(MAX_ITER - 1);

  state_t     state, state_nxt;
  logic [7:0] mcand, mcand_nxt;
  logic [7:0] mplier, mplier_nxt;
  logic [7:0] acc, acc_nxt;
  logic [2:0] iter, iter_nxt;
  logic [7:0] product, product_nxt;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state   <= S_IDLE;
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
      iter    <= '0;
      product <= '0;
    end else begin
      state   <= state_nxt;
      mcand   <= mcand_nxt;
      mplier  <= mplier_nxt;
      acc     <= acc_nxt;
      iter    <= iter_nxt;
      product <= product_nxt;
    end
  end

  // Each state presents its ALU operation and consumes the result at its exit edge.
  always_comb begin
    state_nxt    = state;
    mcand_nxt    = mcand;
    mplier_nxt   = mplier;
    acc_nxt      = acc;
    iter_nxt     = iter;
    product_nxt  = product;
    alu_opcode_o = OP_AND;
    alu_rs_o     = '0;
    alu_rt_o     = '0;

    unique case (state)
      S_IDLE: begin
        if (bus.start_i) begin
          mcand_nxt  = bus.a_i;
          mplier_nxt = bus.b_i;
          acc_nxt    = '0;
          iter_nxt   = '0;
          state_nxt  = S_CHK;
        end
      end
      S_CHK: begin
        alu_opcode_o = OP_SEQ;
        alu_rs_o     = mplier;
        if (alu_zero_i) begin
          product_nxt = acc;
          state_nxt   = S_DONE;
        end else if (mplier[0]) begin
          state_nxt = S_ADD;
        end else begin
          state_nxt = S_SHL;
        end
      end
      S_ADD: begin
        alu_opcode_o = OP_ADD;
        alu_rs_o     = acc;
        alu_rt_o     = mcand;
        acc_nxt      = alu_result_i;
        state_nxt    = S_SHL;
      end
      S_SHL: begin
        alu_opcode_o = OP_SLL;
        alu_rs_o     = mcand;
        alu_rt_o     = 8'd1;
        mcand_nxt    = alu_result_i;
        state_nxt    = S_SHR;
      end
      S_SHR: begin
        alu_opcode_o = OP_SRL;
        alu_rs_o     = mplier;
        mplier_nxt   = alu_result_i;
        iter_nxt     = iter + 3'd1;
        if (iter == LAST_ITER) begin
          product_nxt = acc;
          state_nxt   = S_DONE;
        end else begin
          state_nxt = S_CHK;
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_comb begin
    bus.busy_o    = (state == S_CHK) || (state == S_ADD) ||
                    (state == S_SHL) || (state == S_SHR);
    bus.done_o    = (state == S_DONE);
    bus.product_o = product;
  end

endmodule

// File: tb/tb_alu_mul_seq.sv
// Directed plus random checks of the MUL sequencer against an arithmetic reference.
module tb_alu_mul_seq;
  logic       clk;
  logic       reset;
  logic [2:0] alu_opcode;
  logic [7:0] alu_rs, alu_rt, alu_result;
  logic       alu_zero;

  int checks = 0;
  int errors = 0;
  logic [2:0] exp_ops[$];

  alu_mul_seq_if bus ();

  alu_mul_seq #(.MAX_ITER(8)) dut (
    .clk_i        (clk),
    .reset_i      (reset),
    .bus          (bus),
    .alu_opcode_o (alu_opcode),
    .alu_rs_o     (alu_rs),
    .alu_rt_o     (alu_rt),
    .alu_result_i (alu_result),
    .alu_zero_i   (alu_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural stand-in for the shared combinational ALU.
  always_comb begin
    case (alu_opcode)
      3'b000:  alu_result = alu_rs & alu_rt;
      3'b001:  alu_result = alu_rs + alu_rt;
      3'b010:  alu_result = alu_rs << alu_rt[2:0];
      3'b011:  alu_result = alu_rs >> 1;
      default: alu_result = 8'h00;
    endcase
    alu_zero = (alu_opcode == 3'b111) ? (alu_rs == alu_rt) : (alu_result == 8'h00);
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Expected busy length and opcode trace: one pass per multiplier bit up to the
  // highest set bit, plus a terminating zero test unless all 8 bits were consumed.
  task automatic model(input logic [7:0] b, output int busy_len);
    int n = 0;
    logic [7:0] bv = b;
    exp_ops.delete();
    for (int i = 0; i < 8; i++) if (bv[i]) n = i + 1;
    busy_len = 0;
    for (int i = 0; i < n; i++) begin
      exp_ops.push_back(3'b111);
      if (bv[i]) exp_ops.push_back(3'b001);
      exp_ops.push_back(3'b010);
      exp_ops.push_back(3'b011);
      busy_len += bv[i] ? 4 : 3;
    end
    if (n < 8) begin
      exp_ops.push_back(3'b111);
      busy_len += 1;
    end
  endtask

  task automatic run_mul(input logic [7:0] a, input logic [7:0] b);
    int busy_len, busy_n, done_cyc, idx;
    bit ops_ok;
    logic [7:0] exp_p;
    exp_p = 8'((int'(a) * int'(b)) & 255);
    model(b, busy_len);
    busy_n = 0; done_cyc = 0; idx = 0; ops_ok = 1'b1;
    @(negedge clk);
    bus.start_i = 1'b1; bus.a_i = a; bus.b_i = b;
    @(posedge clk);
    #1;
    bus.start_i = 1'b0; bus.a_i = 8'($urandom); bus.b_i = 8'($urandom);
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (bus.busy_o) begin
        busy_n++;
        if (idx >= exp_ops.size() || alu_opcode !== exp_ops[idx]) ops_ok = 1'b0;
        idx++;
      end
      if (bus.done_o) begin
        done_cyc = c;
        break;
      end
    end
    chk($sformatf("done_cycle a=%0h b=%0h", a, b), done_cyc, busy_len + 1);
    chk($sformatf("busy_cycles a=%0h b=%0h", a, b), busy_n, busy_len);
    chk($sformatf("opcode_trace a=%0h b=%0h", a, b), int'(ops_ok && idx == exp_ops.size()), 1);
    chk($sformatf("product a=%0h b=%0h", a, b), int'(bus.product_o), int'(exp_p));
    @(negedge clk);
    chk("done_pulse_width", int'(bus.done_o), 0);
    chk("product_hold", int'(bus.product_o), int'(exp_p));
  endtask

  initial begin
    int dones, first_done, second_done, busy_len, ndone;
    reset = 1'b1;
    bus.start_i = 1'b0; bus.a_i = '0; bus.b_i = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_busy", int'(bus.busy_o), 0);
    chk("reset_done", int'(bus.done_o), 0);
    chk("reset_product", int'(bus.product_o), 0);
    chk("reset_opcode", int'(alu_opcode), 0);
    reset = 1'b0;

    run_mul(8'h37, 8'h00);
    run_mul(8'h05, 8'h01);
    run_mul(8'h10, 8'h10);
    run_mul(8'h0F, 8'hFF);
    run_mul(8'h03, 8'h80);
    for (int k = 0; k < 25; k++) run_mul(8'($urandom), 8'($urandom));

    // Reset in cycle 10 of a long multiply aborts it silently.
    @(negedge clk);
    bus.start_i = 1'b1; bus.a_i = 8'h03; bus.b_i = 8'hFF;
    @(posedge clk);
    #1 bus.start_i = 1'b0;
    for (int c = 1; c <= 10; c++) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_busy", int'(bus.busy_o), 0);
    chk("abort_done", int'(bus.done_o), 0);
    chk("abort_product", int'(bus.product_o), 0);
    reset = 1'b0;
    ndone = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus.done_o) ndone++;
    end
    chk("abort_no_done", ndone, 0);

    // start held high: DONE ignores it, the following IDLE accepts it.
    model(8'h03, busy_len);
    @(negedge clk);
    bus.start_i = 1'b1; bus.a_i = 8'h02; bus.b_i = 8'h03;
    @(posedge clk);
    dones = 0; first_done = 0; second_done = 0;
    for (int c = 1; c <= 2 * (busy_len + 1) + 1; c++) begin
      @(negedge clk);
      if (bus.done_o) begin
        dones++;
        if (dones == 1) begin
          first_done = c;
          chk("hold_first_product", int'(bus.product_o), 6);
        end else if (dones == 2) begin
          second_done = c;
        end
      end
    end
    bus.start_i = 1'b0;
    chk("hold_first_done_cycle", first_done, busy_len + 1);
    chk("hold_second_done_cycle", second_done, 2 * (busy_len + 1) + 1);
    chk("hold_done_count", dones, 2);
    repeat (40) @(negedge clk);
    chk("hold_idle_after_release", int'(bus.busy_o), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
